// File: rtl/add_pkg.sv
// Shared types and constants for the accumulate stage that sits in front of an external 32-bit adder.
// The optional saturation feature is controlled by the ACC_SAT_EN macro.
package add_pkg;

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

    // The clamp direction follows the sign of the accumulator-side operand.
    function automatic logic [31:0] sat_value(input logic a_sign);
        return a_sign ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/add_acc_stage.sv
// Burst accumulator driving an external 32-bit adder; one result per burst.
// Define ACC_SAT_EN to clamp the accumulator on signed overflow instead of wrapping.
module add_acc_stage
    import add_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [31:0]      op_data,
    input  logic             op_sub,
    input  logic             op_clr,
    input  logic             op_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_cin,
    input  logic [31:0]      add_sum,
    input  logic             add_cout,
    input  logic             add_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_ovf,
    output logic [CNT_W-1:0] res_cnt,
    output state_t           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // op_ready depends only on state, never on op_valid, and payloads hold while valid waits.

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [31:0]      acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             release_res;
    logic [31:0]      acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             unused_cout;

    // Carry-out carries no meaning for signed accumulation.
    assign unused_cout = add_cout;

    assign add_a   = op_clr ? 32'h0 : acc;
    assign add_b   = op_sub ? ~op_data : op_data;
    assign add_cin = op_sub;

    assign op_ready    = (state == ST_ACC);
    assign res_valid   = (state == ST_OUT);
    assign accept      = op_valid & op_ready;
    assign release_res = res_valid & res_ready;

    assign res_data  = acc;
    assign res_ovf   = ovf;
    assign res_cnt   = cnt;
    assign dbg_state = state;

    always_comb begin
        acc_next = add_sum;
`ifdef ACC_SAT_EN
        if (add_ovf) begin
            acc_next = sat_value(add_a[31]);
        end
`endif
    end

    always_comb begin
        cnt_next = cnt;
        if (op_clr) begin
            cnt_next = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
            acc   <= 32'h0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                acc <= acc_next;
                ovf <= (op_clr ? 1'b0 : ovf) | add_ovf;
                cnt <= cnt_next;
                if (op_last) begin
                    state <= ST_OUT;
                end
            end else if (release_res) begin
                state <= ST_ACC;
                acc   <= 32'h0;
                ovf   <= 1'b0;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_add_acc_stage.sv
// Directed bench for add_acc_stage: two instances (CNT_W=8 and CNT_W=2) share stimulus,
// each with its own behavioural 32-bit adder.
module tb_add_acc_stage;
    import add_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [31:0] op_data;
    logic        op_sub;
    logic        op_clr;
    logic        op_last;
    logic        res_ready;

    logic        op_ready, res_valid, res_ovf;
    logic [31:0] add_a, add_b, add_sum, res_data;
    logic        add_cin, add_cout, add_ovf;
    logic [7:0]  res_cnt;
    state_t      dbg_state;

    logic        op_ready2, res_valid2, res_ovf2;
    logic [31:0] add_a2, add_b2, add_sum2, res_data2;
    logic        add_cin2, add_cout2, add_ovf2;
    logic [1:0]  res_cnt2;
    state_t      dbg_state2;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {32'h0, add_cin};
    assign add_ovf               = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
    assign {add_cout2, add_sum2} = {1'b0, add_a2} + {1'b0, add_b2} + {32'h0, add_cin2};
    assign add_ovf2              = (add_a2[31] == add_b2[31]) && (add_sum2[31] != add_a2[31]);

    add_acc_stage #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_data(op_data), .op_sub(op_sub), .op_clr(op_clr), .op_last(op_last),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .res_cnt(res_cnt), .dbg_state(dbg_state)
    );

    add_acc_stage #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready2),
        .op_data(op_data), .op_sub(op_sub), .op_clr(op_clr), .op_last(op_last),
        .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
        .add_sum(add_sum2), .add_cout(add_cout2), .add_ovf(add_ovf2),
        .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
        .res_ovf(res_ovf2), .res_cnt(res_cnt2), .dbg_state(dbg_state2)
    );

    task automatic send_op(input logic [31:0] d, input logic sub, input logic clr,
                           input logic last, input string name);
        logic ok;
        ok = 1'b0;
        op_data = d; op_sub = sub; op_clr = clr; op_last = last; op_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (op_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        op_valid = 1'b0; op_clr = 1'b0; op_last = 1'b0; op_sub = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: op_ready never seen, got %b want 1", name, ok);
        end
    endtask

    task automatic wait_res(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s res_valid: timeout, got %b want 1", name, ok);
        end
    endtask

    task automatic ack_res(input string name);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: res_valid=%b op_ready=%b want 0/1", name, res_valid, op_ready);
        end
        checks++;
        if (res_data !== 32'h0 || res_cnt !== 8'd0 || res_ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s clear: data=%h cnt=%0d ovf=%b want 0/0/0", name, res_data, res_cnt, res_ovf);
        end
    endtask

    task automatic get_result(input logic [31:0] exp_d, input logic exp_o,
                              input logic [7:0] exp_c, input string name);
        wait_res(name);
        checks++;
        if (res_data !== exp_d) begin
            errors++;
            $display("FAIL %s res_data: got %h want %h", name, res_data, exp_d);
        end
        checks++;
        if (res_ovf !== exp_o) begin
            errors++;
            $display("FAIL %s res_ovf: got %b want %b", name, res_ovf, exp_o);
        end
        checks++;
        if (res_cnt !== exp_c) begin
            errors++;
            $display("FAIL %s res_cnt: got %0d want %0d", name, res_cnt, exp_c);
        end
        ack_res(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b0; op_data = '0; op_sub = 1'b0;
        op_clr = 1'b0; op_last = 1'b0; res_ready = 1'b0;
        #3;
        checks++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0 || dbg_state !== ST_ACC) begin
            errors++;
            $display("FAIL reset state: op_ready=%b res_valid=%b want 1/0", op_ready, res_valid);
        end
        checks++;
        if (res_data !== 32'h0 || res_cnt !== 8'd0 || res_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset regs: data=%h cnt=%0d ovf=%b want 0/0/0", res_data, res_cnt, res_ovf);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_operands();
        op_data = 32'd3; op_sub = 1'b1; op_clr = 1'b1;
        #1;
        checks++;
        if (add_a !== 32'h0 || add_b !== 32'hFFFF_FFFC || add_cin !== 1'b1) begin
            errors++;
            $display("FAIL operands sub/clr: a=%h b=%h cin=%b want 0/fffffffc/1", add_a, add_b, add_cin);
        end
        op_sub = 1'b0; op_clr = 1'b0;
        #1;
        checks++;
        if (add_b !== 32'd3 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL operands add: b=%h cin=%b want 3/0", add_b, add_cin);
        end
    endtask

    task automatic test_basic();
        send_op(32'd5, 1'b0, 1'b1, 1'b0, "basic_op0");
        send_op(32'd7, 1'b0, 1'b0, 1'b0, "basic_op1");
        send_op(32'd3, 1'b1, 1'b0, 1'b1, "basic_op2");
        get_result(32'd9, 1'b0, 8'd3, "basic");
    endtask

    task automatic test_ovf_pos();
        send_op(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, "ovfpos_op0");
        send_op(32'd1, 1'b0, 1'b0, 1'b1, "ovfpos_op1");
`ifdef ACC_SAT_EN
        get_result(32'h7FFF_FFFF, 1'b1, 8'd2, "ovf_pos");
`else
        get_result(32'h8000_0000, 1'b1, 8'd2, "ovf_pos");
`endif
    endtask

    task automatic test_ovf_neg();
        send_op(32'h8000_0000, 1'b0, 1'b1, 1'b0, "ovfneg_op0");
        send_op(32'd1, 1'b1, 1'b0, 1'b1, "ovfneg_op1");
`ifdef ACC_SAT_EN
        get_result(32'h8000_0000, 1'b1, 8'd2, "ovf_neg");
`else
        get_result(32'h7FFF_FFFF, 1'b1, 8'd2, "ovf_neg");
`endif
    endtask

    task automatic test_backpressure();
        send_op(32'd1, 1'b0, 1'b1, 1'b0, "bp_op0");
        send_op(32'd2, 1'b0, 1'b0, 1'b1, "bp_op1");
        wait_res("bp");
        op_data = 32'd100; op_valid = 1'b1; op_last = 1'b1; res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (op_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 32'd3 ||
                res_cnt !== 8'd2 || res_ovf !== 1'b0) begin
                errors++;
                $display("FAIL bp hold %0d: op_ready=%b valid=%b data=%h cnt=%0d want 0/1/3/2",
                         i, op_ready, res_valid, res_data, res_cnt);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0) begin
            errors++;
            $display("FAIL bp release: op_ready=%b valid=%b data=%h want 1/0/0", op_ready, res_valid, res_data);
        end
        @(posedge clk); #1;
        op_valid = 1'b0; op_last = 1'b0;
        get_result(32'd100, 1'b0, 8'd1, "bp_next");
    endtask

    task automatic test_cnt_sat();
        send_op(32'd1, 1'b0, 1'b1, 1'b0, "sat_op0");
        for (int i = 0; i < 4; i++) send_op(32'd1, 1'b0, 1'b0, 1'b0, "sat_opn");
        send_op(32'd1, 1'b0, 1'b0, 1'b1, "sat_last");
        wait_res("cnt_sat");
        checks++;
        if (res_cnt2 !== 2'd3 || res_data2 !== 32'd6 || res_valid2 !== 1'b1) begin
            errors++;
            $display("FAIL cnt_sat narrow: cnt=%0d data=%h valid=%b want 3/6/1", res_cnt2, res_data2, res_valid2);
        end
        checks++;
        if (res_cnt !== 8'd6 || res_data !== 32'd6) begin
            errors++;
            $display("FAIL cnt_sat wide: cnt=%0d data=%h want 6/6", res_cnt, res_data);
        end
        ack_res("cnt_sat");
    endtask

    task automatic test_reset_mid();
        send_op(32'd10, 1'b0, 1'b1, 1'b0, "rst_op0");
        send_op(32'd20, 1'b0, 1'b0, 1'b0, "rst_op1");
        op_valid = 1'b1; op_data = 32'd30; op_last = 1'b1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (res_valid !== 1'b0 || res_data !== 32'h0 || res_cnt !== 8'd0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b data=%h cnt=%0d ready=%b want 0/0/0/1",
                     res_valid, res_data, res_cnt, op_ready);
        end
        op_valid = 1'b0; op_last = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid no result: res_valid=%b want 0", res_valid);
        end
        send_op(32'd4, 1'b0, 1'b1, 1'b1, "rst_single");
        get_result(32'd4, 1'b0, 8'd1, "reset_single");
    endtask

    initial begin
        test_reset();
        test_operands();
        test_basic();
        test_ovf_pos();
        test_ovf_neg();
        test_backpressure();
        test_cnt_sat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_acc_stage.md
ADD_ACC_STAGE -- requirements
Module: add_acc_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the per-burst operation counter.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port op_valid  input  1 and op_ready  output  1: operand handshake.
REQ-005 SHALL have port op_data  input  32: two's-complement operand.
REQ-006 SHALL have ports op_sub  input  1 (subtract), op_clr  input  1 (load, not accumulate) and op_last  input  1 (close burst).
REQ-007 SHALL have ports add_a  output  32, add_b  output  32, add_cin  output  1: operands driven to the external 32-bit adder.
REQ-008 SHALL have ports add_sum  input  32, add_cout  input  1, add_ovf  input  1: external adder results, combinational from add_a/add_b/add_cin.
REQ-009 SHALL have ports res_valid  output  1, res_ready  input  1, res_data  output  32, res_ovf  output  1, res_cnt  output  CNT_W: result handshake and payload.

Function
REQ-010 SHALL implement FSM states ACC and OUT; op_ready = 1 only in ACC; res_valid = 1 only in OUT.
REQ-011 SHALL drive add_a = (op_clr ? 0 : acc), add_b = (op_sub ? ~op_data : op_data), add_cin = op_sub, combinationally from current inputs in every state.
REQ-012 SHALL on accept (op_valid & op_ready) load acc <= add_sum on the same edge; zero added latency beyond one register.
REQ-013 SHALL on accept set sticky ovf <= (op_clr ? 0 : ovf) | add_ovf; add_cout is ignored for accumulation.
REQ-014 SHALL on accept set cnt <= (op_clr ? 1 : cnt + 1), saturating at 2^CNT_W-1 (no wrap).
REQ-015 SHALL on accept with op_last=1 transition ACC->OUT; res_valid asserts the following cycle with res_data = new acc, res_ovf, res_cnt.
REQ-016 SHALL hold res_data/res_ovf/res_cnt stable while res_valid=1 and res_ready=0.
REQ-017 SHALL on res_valid & res_ready transition OUT->ACC and clear acc, ovf and cnt to 0 on that edge.
REQ-018 SHALL ignore op_valid in OUT (op_ready=0); no operand is lost or consumed.
REQ-019 SHALL treat op_clr & op_last on one accept as a single-operand burst (res_cnt = 1).
REQ-020 SHALL leave acc, ovf, cnt unchanged in cycles without accept.

Reset
REQ-021 SHALL on rst_n=0, asynchronously: state=ACC, acc=0, ovf=0, cnt=0, res_valid=0, op_ready=1 after release.
REQ-022 SHALL abandon any in-progress burst or pending result on reset mid-operation; no result emitted for it.

Configuration
REQ-023 SHALL support macro ACC_SAT_EN: when defined, an accept with add_ovf=1 loads acc with 32'h7FFF_FFFF if add_a[31]=0 else 32'h8000_0000 (ovf still set).
REQ-024 SHALL without ACC_SAT_EN load acc with the wrapped add_sum on overflow.

Structure
REQ-025 SHALL place the FSM state enum and saturation constants (SAT_POS, SAT_NEG) in shared package add_pkg.
REQ-026 SHALL be a single module; the 32-bit adder stays external and is not instantiated inside.

Verification
REQ-027 SHALL cover: ops +5(clr), +7, -3(last) -> res_data=9, res_ovf=0, res_cnt=3.
REQ-028 SHALL cover: 0x7FFF_FFFF(clr) then +1(last) -> res_ovf=1; res_data=0x8000_0000 without ACC_SAT_EN, 0x7FFF_FFFF with it.
REQ-029 SHALL cover: res_ready held 0 for 5 cycles with op_valid=1 -> op_ready=0, payload stable, no accept; then res_ready=1 -> ACC, next burst starts from acc=0.
REQ-030 SHALL cover: CNT_W=2, 5 accepts then last -> res_cnt=3 (saturated).
REQ-031 SHALL cover: rst_n pulsed low mid-burst after 2 accepts -> res_valid=0, acc=0; subsequent single op 4 (clr,last) -> res_data=4, res_cnt=1.
REQ-032 SHALL cover: 0x8000_0000(clr) then -1(last) -> res_ovf=1; res_data=0x7FFF_FFFF without ACC_SAT_EN, 0x8000_0000 with it.
